// File: rtl/fifo_word_reader.sv
// Pulls bytes from an upstream byte FIFO (1-cycle read latency) and packs them
// little-endian into 32-bit words, emitting partial words on flush.
module fifo_word_reader (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic [7:0]  fifo_data,
  input  logic        flush,
  output logic [31:0] word_out,
  output logic [3:0]  byte_en,
  output logic        word_valid,
  input  logic        word_ready
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t     state;
  logic [2:0] count;
  logic       rd_q;        // byte from last cycle's read is on fifo_data now
  logic       flush_pend;

  logic       cap;
  logic [1:0] lane;
  logic [2:0] new_count;
  logic       pend_n;
  logic       emit;
  logic       issue;

  always_comb begin
    cap       = (state == FILL) && rd_q;
    lane      = count[1:0];
    new_count = count + {2'b00, cap};
    // a flush only matters if there is, or soon will be, at least one byte
    pend_n    = flush_pend | (flush & ((count != 3'd0) | rd_q | fifo_rd_en));
    emit      = (new_count == 3'd4) | (pend_n & ~fifo_rd_en & (new_count != 3'd0));
    issue     = ~fifo_empty & ~pend_n & ((new_count + {2'b00, fifo_rd_en}) < 3'd4);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      count      <= 3'd0;
      rd_q       <= 1'b0;
      flush_pend <= 1'b0;
      fifo_rd_en <= 1'b0;
      word_valid <= 1'b0;
      word_out   <= 32'h0;
      byte_en    <= 4'b0000;
    end else begin
      case (state)
        FILL: begin
          rd_q <= fifo_rd_en;
          if (cap) begin
            word_out[{lane, 3'b000} +: 8] <= fifo_data;
            byte_en[lane]                 <= 1'b1;
            count                         <= new_count;
          end
          if (emit) begin
            state      <= HOLD;
            word_valid <= 1'b1;
            flush_pend <= 1'b0;
            fifo_rd_en <= 1'b0;
          end else begin
            flush_pend <= pend_n;
            fifo_rd_en <= issue;
          end
        end
        HOLD: begin
          rd_q       <= 1'b0;
          fifo_rd_en <= 1'b0;
          if (word_ready) begin
            state      <= FILL;
            word_valid <= 1'b0;
            count      <= 3'd0;
            word_out   <= 32'h0;
            byte_en    <= 4'b0000;
            fifo_rd_en <= ~fifo_empty;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_word_reader.sv
// Directed bench for fifo_word_reader: behavioural byte FIFO (look-ahead empty),
// a table of single-word vectors and hand sequences for timing corner cases.
module tb_fifo_word_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  fifo_data = 8'h00;
  logic        flush = 1'b0;
  logic [31:0] word_out;
  logic [3:0]  byte_en;
  logic        word_valid;
  logic        word_ready = 1'b0;

  int compared = 0;
  int mismatched = 0;

  fifo_word_reader dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_data(fifo_data), .flush(flush), .word_out(word_out), .byte_en(byte_en),
    .word_valid(word_valid), .word_ready(word_ready)
  );

  always #5 clk = ~clk;

  // upstream FIFO model; empty looks ahead past the pop already being requested
  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int uflow  = 0;
  logic gate = 1'b0;
  assign fifo_empty = gate || (wr_ptr <= rd_ptr + (fifo_rd_en ? 1 : 0));

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (rd_ptr >= wr_ptr) uflow <= uflow + 1;
      fifo_data <= mem[rd_ptr[7:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  typedef struct {
    int          n;
    logic [31:0] bytes;
    logic        fl;
    logic [31:0] w;
    logic [3:0]  be;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    mem[wr_ptr[7:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_valid(input int bound, input string nm);
    for (int k = 0; k < bound && !word_valid; k++) tick();
    chk(nm, {31'h0, word_valid}, 32'h1);
  endtask

  task automatic handshake(input string nm);
    word_ready = 1'b1;
    tick();
    chk(nm, {31'h0, word_valid}, 32'h0);
    word_ready = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] bb;
    bb = v.bytes;
    for (int i = 0; i < v.n; i++) push_byte(bb[8*i +: 8]);
    if (v.fl) begin
      repeat (8) tick();
      chk("pre-flush valid", {31'h0, word_valid}, 32'h0);
      pulse_flush();
    end
    wait_valid(16, "vec valid");
    chk("vec word", word_out, v.w);
    chk("vec byte_en", {28'h0, byte_en}, {28'h0, v.be});
    handshake("vec drop");
  endtask

  initial begin
    logic [7:0]  rdv, vv;
    logic [31:0] got_w;
    logic        seen;
    logic [31:0] got [$];

    vecs[0] = '{4, 32'h44332211, 1'b0, 32'h44332211, 4'b1111};
    vecs[1] = '{2, 32'h00005AA5, 1'b1, 32'h00005AA5, 4'b0011};
    vecs[2] = '{1, 32'h0000007E, 1'b1, 32'h0000007E, 4'b0001};
    vecs[3] = '{3, 32'h00030201, 1'b1, 32'h00030201, 4'b0111};
    vecs[4] = '{4, 32'h018000FF, 1'b0, 32'h018000FF, 4'b1111};
    vecs[5] = '{4, 32'hEFBEADDE, 1'b0, 32'hEFBEADDE, 4'b1111};

    // reset state
    repeat (3) tick();
    chk("rst rd_en", {31'h0, fifo_rd_en}, 32'h0);
    chk("rst valid", {31'h0, word_valid}, 32'h0);
    chk("rst word", word_out, 32'h0);
    chk("rst byte_en", {28'h0, byte_en}, 32'h0);
    rst = 1'b0;
    tick();

    // four back-to-back reads, word valid for exactly one cycle with ready high
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    word_ready = 1'b1;
    got_w = 32'h0;
    for (int c = 0; c < 8; c++) begin
      tick();
      rdv[c] = fifo_rd_en;
      vv[c]  = word_valid;
      if (word_valid) got_w = word_out;
    end
    word_ready = 1'b0;
    chk("burst rd_en pattern", {24'h0, rdv}, 32'h0000000F);
    chk("burst valid pattern", {24'h0, vv}, 32'h00000020);
    chk("burst word", got_w, 32'h44332211);

    // downstream stalls five cycles
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    wait_valid(16, "stall valid");
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("stall hold valid", {31'h0, word_valid}, 32'h1);
      chk("stall hold word", word_out, 32'h44332211);
      chk("stall hold rd_en", {31'h0, fifo_rd_en}, 32'h0);
    end
    handshake("stall drop");

    // flush with nothing collected and nothing in flight is ignored
    pulse_flush();
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      seen = seen | word_valid | fifo_rd_en;
    end
    chk("idle flush ignored", {31'h0, seen}, 32'h0);

    // flush while the only byte is still in flight
    push_byte(8'h3C);
    for (int k = 0; k < 4 && !fifo_rd_en; k++) tick();
    pulse_flush();
    wait_valid(8, "inflight flush valid");
    chk("inflight flush word", word_out, 32'h0000003C);
    chk("inflight flush be", {28'h0, byte_en}, 32'h1);
    handshake("inflight flush drop");

    // flush coincides with the fourth capture: full word, flush dropped
    push_byte(8'hA1); push_byte(8'hB2); push_byte(8'hC3); push_byte(8'hD4);
    repeat (5) tick();
    pulse_flush();
    chk("flush+4th valid", {31'h0, word_valid}, 32'h1);
    chk("flush+4th word", word_out, 32'hD4C3B2A1);
    chk("flush+4th be", {28'h0, byte_en}, 32'hF);
    handshake("flush+4th drop");
    push_byte(8'h5C);
    repeat (6) tick();
    chk("no stale flush", {31'h0, word_valid}, 32'h0);
    pulse_flush();
    wait_valid(8, "after stale valid");
    chk("after stale word", word_out, 32'h0000005C);
    chk("after stale be", {28'h0, byte_en}, 32'h1);
    handshake("after stale drop");

    // bursty FIFO: eight bytes over two words
    for (int i = 1; i <= 8; i++) push_byte(i[7:0]);
    word_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (word_valid) got.push_back(word_out);
      gate = ~gate;
    end
    gate = 1'b0;
    word_ready = 1'b0;
    chk("bursty word count", got.size(), 32'd2);
    if (got.size() >= 2) begin
      chk("bursty word0", got[0], 32'h04030201);
      chk("bursty word1", got[1], 32'h08070605);
    end

    // reset with two bytes captured and the third on the data bus
    push_byte(8'h91); push_byte(8'h92); push_byte(8'h93);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("midrst rd_en", {31'h0, fifo_rd_en}, 32'h0);
    chk("midrst valid", {31'h0, word_valid}, 32'h0);
    chk("midrst word", word_out, 32'h0);
    chk("midrst be", {28'h0, byte_en}, 32'h0);
    rst = 1'b0;
    repeat (3) tick();
    chk("midrst discard be", {28'h0, byte_en}, 32'h0);
    chk("midrst discard word", word_out, 32'h0);

    foreach (vecs[i]) run_vec(vecs[i]);

    chk("fifo underflow", uflow, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/fifo_word_reader.md
FIFO_WORD_READER -- requirements
Module: fifo_word_reader

Interface
REQ-001 Parameters: none; byte width fixed at 8, word width fixed at 32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 fifo_empty  input  1  read side of upstream byte FIFO; high = no byte available.
REQ-005 fifo_rd_en  output  1  read strobe to upstream FIFO; one byte popped per high cycle.
REQ-006 fifo_data  input  8  FIFO read data; valid the cycle after fifo_rd_en was high (1-cycle read latency).
REQ-007 flush  input  1  single-cycle request to emit a partially filled word.
REQ-008 word_out  output  32  assembled word, little-endian: first byte in [7:0], fourth in [31:24].
REQ-009 byte_en  output  4  bit i high = byte lane i of word_out holds valid data.
REQ-010 word_valid  output  1  word_out/byte_en valid; held until accepted.
REQ-011 word_ready  input  1  downstream accept; handshake completes when word_valid and word_ready are both high on a rising edge.

Function
REQ-012 States: FILL (collecting bytes) and HOLD (word presented); fifo_rd_en is registered.
REQ-013 In FILL, fifo_rd_en is high in cycle t iff fifo_empty is low and (bytes captured + reads in flight) < 4 and no flush is pending.
REQ-014 Back-to-back reads are allowed; throughput is one byte per cycle while fifo_empty stays low.
REQ-015 A byte is captured into lane = current byte count the cycle after its fifo_rd_en; capture sets the matching byte_en bit and increments the count.
REQ-016 When the count reaches 4, the block enters HOLD with word_valid high, byte_en = 4'b1111, in the cycle after the fourth capture.
REQ-017 In HOLD, fifo_rd_en is low; word_out, byte_en and word_valid are stable until the handshake.
REQ-018 On handshake the block returns to FILL with count 0, byte_en 0, word_out 0; reads may resume the next cycle.
REQ-019 flush in FILL with count > 0 latches a pending flush, blocks new reads, waits for any in-flight byte to be captured, then enters HOLD with the partial word and word_valid high.
REQ-020 Partial word: unfilled lanes of word_out are 0; byte_en has ones only in the filled lanes.
REQ-021 flush in FILL with count = 0 and no read in flight is ignored.
REQ-022 flush in FILL with count = 0 and one read in flight is latched and emits a 1-byte word after capture.
REQ-023 flush in HOLD is ignored and not latched.
REQ-024 flush and a fourth-byte capture in the same cycle: full word emitted, flush discarded.
REQ-025 fifo_empty going high mid-word pauses reads; collected bytes are retained indefinitely.

Reset
REQ-026 While rst is high at a rising edge: fifo_rd_en=0, word_valid=0, word_out=32'h0, byte_en=4'b0000, count=0, state=FILL, pending flush cleared.
REQ-027 Reset mid-operation discards any in-flight FIFO byte; data arriving on fifo_data the cycle after reset is not captured.
REQ-028 First fifo_rd_en may assert in the second cycle after rst deasserts.

Verification
REQ-029 FIFO holds 8'h11,8'h22,8'h33,8'h44, word_ready=1 -> fifo_rd_en high 4 consecutive cycles; word_out=32'h44332211, byte_en=4'b1111, word_valid high for exactly one cycle.
REQ-030 Same bytes, word_ready=0 for 5 cycles then 1 -> word_valid held with word_out stable, fifo_rd_en low throughout HOLD, drops one cycle after the handshake.
REQ-031 FIFO holds 8'hA5,8'h5A then empty; flush pulse -> word_out=32'h00005AA5, byte_en=4'b0011, word_valid high.
REQ-032 flush while FIFO empty and count 0 -> no word_valid, no fifo_rd_en.
REQ-033 Eight bytes 8'h01..8'h08 with fifo_empty toggling every other cycle -> words 32'h04030201 then 32'h08070605, in order, none lost or duplicated.
REQ-034 rst asserted after two bytes captured -> all outputs at reset values next cycle; subsequent 4 bytes 8'hDE,8'hAD,8'hBE,8'hEF yield 32'hEFBEADDE.
